// File: rtl/rom_fetch_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_resp_pkg
//  Description : Shared widths, state encoding and constants for the
//                instruction-fetch responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_fetch_resp_pkg;

    // Core-wide bus widths
    localparam int c_reg_bus_w       = 32;
    localparam int c_inst_addr_bus_w = 32;

    // Bytes per instruction word and the counter that walks them
    localparam int          c_byte_cnt = 4;
    localparam int          c_cnt_w    = 3;
    localparam logic [2:0]  c_last_cnt = 3'd4;

    // Enable / disable levels used throughout the core
    localparam logic c_enable  = 1'b1;
    localparam logic c_disable = 1'b0;

    // Fetch FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } fetch_state_t;

endpackage : rom_fetch_resp_pkg
`default_nettype wire

// File: rtl/rom_fetch_resp.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_resp
//  Description : Instruction-fetch responder. Reads four consecutive bytes
//                from a byte-wide synchronous memory and returns them as one
//                little-endian 32-bit word with a single-cycle ready pulse.
//                Optional one-entry last-word cache enabled by defining
//                ROM_FETCH_RESP_HIT_CACHE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_resp
    import rom_fetch_resp_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce_i,
    input  logic [c_inst_addr_bus_w-1:0] addr_i,
    input  logic                         flush_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         ready_o,
    output logic                         busy_o,
    output logic [ADDR_W-1:0]            mem_a_o,
    output logic                         mem_re_o,
    input  logic [7:0]                   mem_din_i
);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [c_cnt_w-1:0]  cnt;
    logic [ADDR_W-1:0]   base;
    logic                hit;
    logic                accept;
    logic                accept_miss;
    logic                accept_hit;
    logic                done;

    // Address bits above the memory space are intentionally ignored
    logic                unused_addr_bits;
    assign unused_addr_bits = ^addr_i[c_inst_addr_bus_w-1:ADDR_W];

    // A new request is taken only from IDLE and only when not being flushed
    assign accept      = (state == ST_IDLE) && ce_i && !flush_i;
    assign accept_miss = accept && !hit;
    assign accept_hit  = accept && hit;

    // Last byte lands on the edge where the counter has reached its end
    assign done = (state == ST_BUSY) && !flush_i && (cnt == c_last_cnt);

`ifdef ROM_FETCH_RESP_HIT_CACHE_EN
    logic [ADDR_W-1:0] tag;
    logic              valid;

    // Remember the address of the last completed word; only reset forgets it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            valid <= c_disable;
        end else if (done) begin
            tag   <= base;
            valid <= c_enable;
        end
    end

    assign hit = valid && (addr_i[ADDR_W-1:0] == tag);
`else
    assign hit = c_disable;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a cache hit is answered without leaving IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_miss) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i || (cnt == c_last_cnt)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Memory-side outputs derived from state and counter; zero when idle
    always_comb begin
        busy_o   = (state == ST_BUSY);
        mem_re_o = c_disable;
        mem_a_o  = '0;
        if (state == ST_BUSY) begin
            mem_re_o = (cnt != c_last_cnt);
            mem_a_o  = base + ADDR_W'(cnt);
        end
    end

    // Counter, base address, byte assembly and ready pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            base    <= '0;
            data_o  <= '0;
            ready_o <= c_disable;
        end else begin
            ready_o <= c_disable;
            case (state)
                ST_IDLE: begin
                    if (accept_miss) begin
                        base <= addr_i[ADDR_W-1:0];
                        cnt  <= '0;
                    end
                    if (accept_hit) begin
                        ready_o <= c_enable;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        cnt <= '0;
                    end else begin
                        // Byte read at base+k-1 arrives while cnt==k
                        for (int i = 0; i < c_byte_cnt; i++) begin
                            if (cnt == c_cnt_w'(i + 1)) begin
                                data_o[i*8 +: 8] <= mem_din_i;
                            end
                        end
                        if (cnt == c_last_cnt) begin
                            cnt     <= '0;
                            ready_o <= c_enable;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule : rom_fetch_resp
`default_nettype wire
